llc_port_arbiter: RTL and testbench

- Shares one lower-level cache (LLC/DRAM controller) port between N higher-level caches, e.g. L1I, L1D and TLB miss paths.
- Each requester issues line reads (misses) or line writes (evictions). The arbiter grants one at a time, round-robin.
- It forwards the granted request downstream, waits for read data and routes the returned line back to the owner.
- One transaction is outstanding at a time. A watchdog re-issues reads that get no response.

---
 rtl/llc_arb_pkg.sv | 27 ++
 rtl/llc_port_arbiter_rr_picker.sv | 21 ++
 rtl/llc_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_llc_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_arb_pkg.sv
// Shared types for the LLC port arbiter: FSM states, line/request types, line-address helper.
package llc_arb_pkg;

  localparam int unsigned LLC_ADDR_BITS = 64;
  localparam int unsigned LLC_B         = 64;
  localparam int unsigned LLC_OFF_BITS  = $clog2(LLC_B);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RETURN   = 2'd3
  } arb_state_t;

  typedef logic [LLC_B*8-1:0] line_t;

  typedef struct packed {
    logic                     we;
    logic [LLC_ADDR_BITS-1:0] addr;
    line_t                    line;
  } arb_req_t;

  function automatic logic [LLC_ADDR_BITS-1:0] line_addr(input logic [LLC_ADDR_BITS-1:0] a);
    line_addr = {a[LLC_ADDR_BITS-1:LLC_OFF_BITS], {LLC_OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/llc_port_arbiter_rr_picker.sv
// Round-robin picker: first set request bit strictly after last_i, wrapping; purely combinational.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  // Scan from farthest to nearest so the nearest candidate after last_i overwrites the rest.
  always_comb begin
    grant_o = '0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % N]) grant_o = IW'((int'(last_i) + k) % N);
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/llc_port_arbiter.sv
// Shares one LLC port among N requesters round-robin, one transaction in flight; reads are
// watchdog re-issued. Outputs come only from registers; requesters/downstream stall via valid/ready.
module llc_port_arbiter
  import llc_arb_pkg::*;
#(
  parameter int N              = 2,
  parameter int ADDR_BITS      = LLC_ADDR_BITS,
  parameter int B              = LLC_B,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_in,
  input  logic                   rst_N_in,
  input  logic [N-1:0]           req_valid_in,
  input  logic [N-1:0]           req_we_in,
  input  logic [N*ADDR_BITS-1:0] req_addr_in,
  input  logic [N*B*8-1:0]       req_line_in,
  output logic [N-1:0]           req_ready_out,
  output logic [N-1:0]           rsp_valid_out,
  input  logic [N-1:0]           rsp_ready_in,
  output logic [ADDR_BITS-1:0]   rsp_addr_out,
  output logic [B*8-1:0]         rsp_line_out,
  output logic                   lc_valid_out,
  input  logic                   lc_ready_in,
  output logic                   lc_we_out,
  output logic [ADDR_BITS-1:0]   lc_addr_out,
  output logic [B*8-1:0]         lc_value_out,
  input  logic                   lc_valid_in,
  input  logic [ADDR_BITS-1:0]   lc_addr_in,
  input  logic [B*8-1:0]         lc_value_in,
  output logic                   lc_ready_out,
  output logic                   timeout_out,
  output logic                   stray_rsp_out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX   = '1;

  if (ADDR_BITS != LLC_ADDR_BITS || B != LLC_B) begin : g_width_chk
    $error("llc_port_arbiter: ADDR_BITS/B must match llc_arb_pkg widths");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  arb_req_t      req_q, req_d;
  logic [WW-1:0] wd_q, wd_d;
  line_t         rsp_line_q, rsp_line_d;
  logic [N-1:0]  req_rdy_q, req_rdy_d;
  logic          stray_q, stray_d;
  logic          tout_q, tout_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_picker #(.N(N), .IW(IW)) u_pick (
    .req_i   (req_valid_in),
    .last_i  (last_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    req_d      = req_q;
    wd_d       = wd_q;
    rsp_line_d = rsp_line_q;
    req_rdy_d  = '0;
    stray_d    = 1'b0;
    tout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          last_d     = pick_idx;
          req_d.we   = req_we_in[pick_idx];
          req_d.addr = line_addr(req_addr_in[int'(pick_idx)*ADDR_BITS +: ADDR_BITS]);
          req_d.line = req_line_in[int'(pick_idx)*B*8 +: B*8];
          req_rdy_d  = N'(1) << pick_idx;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (lc_ready_in) begin
          if (req_q.we) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_RSP;
            wd_d    = '0;
          end
        end
      end
      WAIT_RSP: begin
        if (lc_valid_in) begin
          if (line_addr(lc_addr_in) == req_q.addr) begin
            rsp_line_d = lc_value_in;
            state_d    = RETURN;
          end else begin
            stray_d = 1'b1;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
          // Re-send the latched request unchanged; the requester already got its ready pulse.
          if (wd_d == WD_LIMIT) begin
            tout_d  = 1'b1;
            state_d = ISSUE;
            wd_d    = '0;
          end
        end
      end
      RETURN: begin
        if (rsp_ready_in[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(N - 1);
      req_q      <= '0;
      wd_q       <= '0;
      rsp_line_q <= '0;
      req_rdy_q  <= '0;
      stray_q    <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      req_q      <= req_d;
      wd_q       <= wd_d;
      rsp_line_q <= rsp_line_d;
      req_rdy_q  <= req_rdy_d;
      stray_q    <= stray_d;
      tout_q     <= tout_d;
    end
  end

  assign req_ready_out = req_rdy_q;
  assign lc_valid_out  = (state_q == ISSUE);
  assign lc_we_out     = req_q.we;
  assign lc_addr_out   = req_q.addr;
  assign lc_value_out  = req_q.line;
  assign lc_ready_out  = (state_q == WAIT_RSP);
  assign rsp_valid_out = (state_q == RETURN) ? (N'(1) << grant_q) : '0;
  assign rsp_addr_out  = req_q.addr;
  assign rsp_line_out  = rsp_line_q;
  assign timeout_out   = tout_q;
  assign stray_rsp_out = stray_q;

endmodule

// File: tb/tb_llc_port_arbiter.sv
// Directed bench for llc_port_arbiter with a transaction-level reference model checked every cycle.
module tb_llc_port_arbiter;

  localparam int N  = 2;
  localparam int AB = 64;
  localparam int LB = 64;
  localparam int LW = LB * 8;
  localparam int TO = 8;
  localparam logic [AB-1:0] OFF_MASK = AB'(LB - 1);
  localparam int P_REQRDY = 0, P_LCVLD = 1, P_LCRDY = 2, P_RSPVLD = 3;

  logic           clk_in   = 1'b0;
  logic           rst_N_in = 1'b1;
  logic [N-1:0]   req_valid_in = '0, req_we_in = '0, rsp_ready_in = '0;
  logic [N*AB-1:0] req_addr_in = '0;
  logic [N*LW-1:0] req_line_in = '0;
  logic           lc_ready_in = 1'b0, lc_valid_in = 1'b0;
  logic [AB-1:0]  lc_addr_in = '0;
  logic [LW-1:0]  lc_value_in = '0;
  logic [N-1:0]   req_ready_out, rsp_valid_out;
  logic [AB-1:0]  rsp_addr_out, lc_addr_out;
  logic [LW-1:0]  rsp_line_out, lc_value_out;
  logic           lc_valid_out, lc_we_out, lc_ready_out, timeout_out, stray_rsp_out;

  int errors = 0;
  int checks = 0;

  llc_port_arbiter #(.N(N), .ADDR_BITS(AB), .B(LB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .req_valid_in(req_valid_in), .req_we_in(req_we_in), .req_addr_in(req_addr_in),
    .req_line_in(req_line_in), .req_ready_out(req_ready_out),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_addr_out(rsp_addr_out), .rsp_line_out(rsp_line_out),
    .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_we_out(lc_we_out),
    .lc_addr_out(lc_addr_out), .lc_value_out(lc_value_out),
    .lc_valid_in(lc_valid_in), .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in),
    .lc_ready_out(lc_ready_out), .timeout_out(timeout_out), .stray_rsp_out(stray_rsp_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which transaction is in progress and what phase it is in.
  // phase 0 = nothing owned, 1 = presenting downstream, 2 = awaiting data, 3 = handing back.
  int            m_phase = 0, m_owner = 0, m_last = N - 1, m_wait = 0;
  logic          m_we = 1'b0;
  logic [AB-1:0] m_addr = '0;
  logic [LW-1:0] m_line = '0, m_rsp = '0;
  logic [N-1:0]  e_reqrdy = '0;
  logic          e_stray = 1'b0, e_to = 1'b0;

  task automatic model_step();
    bit picked;
    int idx;
    e_reqrdy = '0;
    e_stray  = 1'b0;
    e_to     = 1'b0;
    picked   = 0;
    case (m_phase)
      0: for (int k = 1; k <= N; k++) begin
           idx = (m_last + k) % N;
           if (!picked && req_valid_in[idx]) begin
             picked  = 1;
             m_owner = idx;
             m_last  = idx;
             m_we    = req_we_in[idx];
             m_addr  = req_addr_in[idx*AB +: AB] & ~OFF_MASK;
             m_line  = req_line_in[idx*LW +: LW];
             e_reqrdy[idx] = 1'b1;
             m_phase = 1;
           end
         end
      1: if (lc_ready_in) begin
           m_phase = m_we ? 0 : 2;
           m_wait  = 0;
         end
      2: if (lc_valid_in) begin
           if ((lc_addr_in & ~OFF_MASK) == m_addr) begin
             m_rsp   = lc_value_in;
             m_phase = 3;
           end else begin
             e_stray = 1'b1;
           end
         end else begin
           m_wait++;
           if (m_wait == TO) begin
             e_to    = 1'b1;
             m_wait  = 0;
             m_phase = 1;
           end
         end
      default: if (rsp_ready_in[m_owner]) m_phase = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk_in or negedge rst_N_in);
    if (!rst_N_in) begin
      m_phase = 0; m_owner = 0; m_last = N - 1; m_wait = 0;
      m_we = 1'b0; m_addr = '0; m_line = '0; m_rsp = '0;
      e_reqrdy = '0; e_stray = 1'b0; e_to = 1'b0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    logic [N-1:0] ev;
    @(negedge clk_in);
    ev = '0;
    if (m_phase == 3) ev[m_owner] = 1'b1;
    chk("m_req_ready", req_ready_out, e_reqrdy);
    chk("m_lc_valid", lc_valid_out, m_phase == 1);
    chk("m_lc_ready", lc_ready_out, m_phase == 2);
    chk("m_rsp_valid", rsp_valid_out, ev);
    chk("m_timeout", timeout_out, e_to);
    chk("m_stray", stray_rsp_out, e_stray);
    if (m_phase == 1) begin
      chk("m_lc_we", lc_we_out, m_we);
      chk("m_lc_addr", lc_addr_out, m_addr);
      chk("m_lc_value", lc_value_out, m_line);
    end
    if (m_phase == 3) begin
      chk("m_rsp_addr", rsp_addr_out, m_addr);
      chk("m_rsp_line", rsp_line_out, m_rsp);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      P_REQRDY: return |req_ready_out;
      P_LCVLD:  return lc_valid_out;
      P_LCRDY:  return lc_ready_out;
      default:  return |rsp_valid_out;
    endcase
  endfunction

  task automatic wait_until(input string nm, input int sel, input int budget);
    int n = 0;
    while (!probe(sel) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, probe(sel), 1'b1);
  endtask

  task automatic respond(input logic [AB-1:0] a, input logic [LW-1:0] v);
    lc_valid_in = 1'b1;
    lc_addr_in  = a;
    lc_value_in = v;
    tick();
    lc_valid_in = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] l0, l1, l2, d0, d1, d2, d3, d4;
    logic [AB-1:0] seen [3];
    int            at [3];
    int            got, n;
    l0 = {8{64'hA0A0_0000_0000_1000}}; l1 = {8{64'hA1A1_0000_0000_2040}};
    l2 = {8{64'hA2A2_0000_0000_5000}};
    d0 = {8{64'hD0D0_1111_2222_3333}}; d1 = {8{64'hD1D1_4444_5555_6666}};
    d2 = {8{64'hD2D2_7777_8888_9999}}; d3 = {8{64'hD3D3_AAAA_BBBB_CCCC}};
    d4 = {8{64'hD4D4_EEEE_FFFF_0123}};
    seen = '{default: '0};
    at   = '{default: 0};

    #1 rst_N_in = 1'b0;
    #1;
    chk("reset_ctrl", {req_ready_out, rsp_valid_out, rsp_addr_out, lc_valid_out, lc_we_out,
                       lc_addr_out, lc_ready_out, timeout_out, stray_rsp_out}, '0);
    chk("reset_lines", {rsp_line_out, lc_value_out} != '0, 1'b0);
    repeat (2) @(posedge clk_in);
    #1 rst_N_in = 1'b1;

    // Simultaneous reads: requester 0 wins first after reset, then requester 1.
    lc_ready_in  = 1'b1;
    rsp_ready_in = 2'b11;
    req_we_in    = 2'b00;
    req_addr_in  = {64'h2040, 64'h1000};
    req_line_in  = {l1, l0};
    req_valid_in = 2'b11;
    tick();
    chk("t2_first_grant", req_ready_out, 2'b01);
    req_valid_in[0] = 1'b0;
    wait_until("t2_wait0", P_LCRDY, 10);
    tick(); tick();
    respond(64'h1000, d0);
    chk("t2_rsp_valid0", rsp_valid_out, 2'b01);
    chk("t2_rsp_addr0", rsp_addr_out, 64'h1000);
    chk("t2_rsp_line0", rsp_line_out, d0);
    wait_until("t2_grant1_seen", P_REQRDY, 10);
    chk("t2_second_grant", req_ready_out, 2'b10);
    req_valid_in = 2'b00;
    wait_until("t2_wait1", P_LCRDY, 10);
    tick(); tick();
    respond(64'h2040, d1);
    chk("t2_rsp_valid1", rsp_valid_out, 2'b10);
    chk("t2_rsp_addr1", rsp_addr_out, 64'h2040);
    chk("t2_rsp_line1", rsp_line_out, d1);
    tick();

    // Backpressure on both the downstream request and the response hand-back.
    lc_ready_in  = 1'b0;
    rsp_ready_in = 2'b01;
    req_addr_in  = {64'h5000, 64'h0};
    req_line_in  = {l2, l0};
    req_valid_in = 2'b10;
    wait_until("t4_grant", P_REQRDY, 10);
    req_valid_in = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("t4_lc_valid_hold", lc_valid_out, 1'b1);
      chk("t4_lc_addr_hold", lc_addr_out, 64'h5000);
      chk("t4_lc_value_hold", lc_value_out, l2);
      tick();
    end
    lc_ready_in = 1'b1;
    tick();
    lc_ready_in = 1'b0;
    respond(64'h5000, d2);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rsp_hold", rsp_valid_out, 2'b10);
      chk("t4_rsp_line_hold", rsp_line_out, d2);
      tick();
    end
    rsp_ready_in = 2'b10;
    tick();
    chk("t4_rsp_done", rsp_valid_out, 2'b00);

    // Both requesters stream writes; grants alternate and each write takes 2 cycles.
    lc_ready_in  = 1'b1;
    req_we_in    = 2'b11;
    req_addr_in  = {64'h80, 64'h40};
    req_line_in  = {l1, l0};
    req_valid_in = 2'b11;
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      tick();
      if (lc_valid_out) begin
        seen[got] = lc_addr_out;
        at[got]   = c;
        got++;
      end
    end
    req_valid_in = 2'b00;
    chk("t3_count", got, 3);
    chk("t3_addr0", seen[0], 64'h40);
    chk("t3_addr1", seen[1], 64'h80);
    chk("t3_addr2", seen[2], 64'h40);
    chk("t3_spacing01", at[1] - at[0], 2);
    chk("t3_spacing12", at[2] - at[1], 2);
    tick(); tick();

    // Stray response is dropped; an in-line offset address still matches the line.
    req_we_in    = 2'b00;
    rsp_ready_in = 2'b01;
    req_addr_in  = {64'h0, 64'h1000};
    req_valid_in = 2'b01;
    wait_until("t5_grant", P_REQRDY, 10);
    req_valid_in = 2'b00;
    wait_until("t5_wait", P_LCRDY, 10);
    respond(64'h3000, d4);
    chk("t5_stray_pulse", stray_rsp_out, 1'b1);
    chk("t5_still_waiting", lc_ready_out, 1'b1);
    tick();
    chk("t5_stray_once", stray_rsp_out, 1'b0);
    respond(64'h1008, d3);
    chk("t5_rsp_valid", rsp_valid_out, 2'b01);
    chk("t5_rsp_addr", rsp_addr_out, 64'h1000);
    chk("t5_rsp_line", rsp_line_out, d3);
    tick();

    // Watchdog: no response for TO cycles re-issues the same read.
    rsp_ready_in = 2'b10;
    req_addr_in  = {64'h7000, 64'h0};
    req_valid_in = 2'b10;
    wait_until("t6_grant", P_REQRDY, 10);
    req_valid_in = 2'b00;
    wait_until("t6_wait", P_LCRDY, 10);
    n = 0;
    while (!timeout_out && n < 20) begin
      tick();
      n++;
    end
    chk("t6_timeout_cycles", n, 8);
    chk("t6_timeout_pulse", timeout_out, 1'b1);
    chk("t6_reissue_valid", lc_valid_out, 1'b1);
    chk("t6_reissue_addr", lc_addr_out, 64'h7000);
    chk("t6_no_reready", req_ready_out, 2'b00);
    tick();
    chk("t6_timeout_once", timeout_out, 1'b0);
    respond(64'h7000, d4);
    chk("t6_rsp_valid", rsp_valid_out, 2'b10);
    tick();

    // Reset while awaiting data: outputs clear at once and arbitration restarts at requester 0.
    req_addr_in  = {64'h0, 64'h2000};
    req_valid_in = 2'b01;
    wait_until("t1_grant", P_REQRDY, 10);
    req_valid_in = 2'b00;
    wait_until("t1_wait", P_LCRDY, 10);
    #2 rst_N_in = 1'b0;
    #1;
    chk("t1_async_ctrl", {req_ready_out, rsp_valid_out, rsp_addr_out, lc_valid_out, lc_we_out,
                          lc_addr_out, lc_ready_out, timeout_out, stray_rsp_out}, '0);
    chk("t1_async_lines", {rsp_line_out, lc_value_out} != '0, 1'b0);
    #3 rst_N_in = 1'b1;
    req_addr_in  = {64'h2040, 64'h1000};
    req_valid_in = 2'b11;
    tick();
    chk("t1_post_reset_grant", req_ready_out, 2'b01);
    req_valid_in = 2'b00;
    rsp_ready_in = 2'b11;
    wait_until("t1_post_wait", P_LCRDY, 10);
    respond(64'h1000, d0);
    chk("t1_post_rsp_addr", rsp_addr_out, 64'h1000);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
